pc_sequencer: RTL

Owns the program counter and sequences instruction fetch from the decoded jump/branch strobes (J, JW, JR, BEQ, BNE, BGEZ) and the execute-side compare flags. It selects next-PC, raises a one-cycle flush after any redirect, and implements a halt/resume state. It also keeps saturating taken-branch and jump counters for the statistics display. It sits between the jump-control decoder and instruction memory.

---
 rtl/pc_sequencer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Program-counter owner and fetch sequencer. Chooses the next
//               PC from decoded jump/branch strobes and execute-side compare
//               flags, emits a one-cycle flush after every redirect, supports
//               a HALT/RUN state, and keeps saturating taken-branch and jump
//               statistics counters.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   in_clk, in_rst         clock (rising edge), synchronous active-high reset
//   in_J/JW/JR             jump, jump-and-link, jump-register strobes
//   in_BEQ/BNE/BGEZ        conditional branch strobes
//   in_equal, in_rs_sign   compare flags (rs==rt, rs[31])
//   in_imm16               branch offset in words
//   in_target26            jump target field
//   in_rs_value            register value for JR
//   in_halt, in_go         halt instruction in execute, resume request
//   in_stall               external hold
//   out_pc                 registered fetch address
//   out_pc_plus4           out_pc + 4 (combinational)
//   out_taken              redirect this cycle (combinational)
//   out_flush              registered one-cycle kill of wrong-path fetch
//   out_halted             high while in HALT
//   out_branch_count       saturating count of taken conditional branches
//   out_jump_count         saturating count of executed J/JW/JR
// ============================================================================
module pc_sequencer #(
  parameter int                  PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
  parameter int                  CNT_WIDTH = 16
) (
  input  logic                 in_clk,
  input  logic                 in_rst,
  input  logic                 in_J,
  input  logic                 in_JW,
  input  logic                 in_JR,
  input  logic                 in_BEQ,
  input  logic                 in_BNE,
  input  logic                 in_BGEZ,
  input  logic                 in_equal,
  input  logic                 in_rs_sign,
  input  logic [15:0]          in_imm16,
  input  logic [25:0]          in_target26,
  input  logic [PC_WIDTH-1:0]  in_rs_value,
  input  logic                 in_halt,
  input  logic                 in_go,
  input  logic                 in_stall,
  output logic [PC_WIDTH-1:0]  out_pc,
  output logic [PC_WIDTH-1:0]  out_pc_plus4,
  output logic                 out_taken,
  output logic                 out_flush,
  output logic                 out_halted,
  output logic [CNT_WIDTH-1:0] out_branch_count,
  output logic [CNT_WIDTH-1:0] out_jump_count
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [PC_WIDTH-1:0]  r_pc;
  logic [PC_WIDTH-1:0]  w_pc_nxt;
  logic                 r_flush;
  logic                 w_flush_nxt;
  logic [CNT_WIDTH-1:0] r_branch_count;
  logic [CNT_WIDTH-1:0] w_branch_count_nxt;
  logic [CNT_WIDTH-1:0] r_jump_count;
  logic [CNT_WIDTH-1:0] w_jump_count_nxt;

  logic [PC_WIDTH-1:0]  w_pc_plus4;
  logic [PC_WIDTH-1:0]  w_jr_target;
  logic [PC_WIDTH-1:0]  w_j_target;
  logic [PC_WIDTH-1:0]  w_br_offset;
  logic [PC_WIDTH-1:0]  w_br_target;
  logic [PC_WIDTH-1:0]  w_target;
  logic                 w_advance;
  logic                 w_cond_taken;
  logic                 w_jump;
  logic                 w_taken;

  assign w_pc_plus4   = r_pc + PC_WIDTH'(4);

  // JR ignores the two low bits so the fetch address stays word-aligned.
  assign w_jr_target  = in_rs_value & ~PC_WIDTH'(3);
  assign w_j_target   = {w_pc_plus4[PC_WIDTH-1:28], in_target26, 2'b00};
  assign w_br_offset  = {{(PC_WIDTH-18){in_imm16[15]}}, in_imm16, 2'b00};
  assign w_br_target  = w_pc_plus4 + w_br_offset;

  // All conditional branches share one target formula, so only the
  // JR > J/JW > branch ordering affects which address is selected.
  assign w_target     = in_JR           ? w_jr_target :
                        (in_J | in_JW)  ? w_j_target  :
                                          w_br_target;

  assign w_advance    = (r_state == ST_RUN) & ~in_stall & ~in_halt;
  assign w_cond_taken = (in_BEQ & in_equal) | (in_BNE & ~in_equal) |
                        (in_BGEZ & ~in_rs_sign);
  assign w_jump       = in_J | in_JW | in_JR;
  assign w_taken      = w_advance & (w_jump | w_cond_taken);

  always_comb begin
    w_state_nxt        = r_state;
    w_pc_nxt           = r_pc;
    w_flush_nxt        = 1'b0;
    w_branch_count_nxt = r_branch_count;
    w_jump_count_nxt   = r_jump_count;
    case (r_state)
      ST_RUN: begin
        // A stall freezes everything; halt only takes effect when not stalled.
        if (!in_stall) begin
          if (in_halt) begin
            w_state_nxt = ST_HALT;
          end else begin
            w_pc_nxt    = w_taken ? w_target : w_pc_plus4;
            w_flush_nxt = w_taken;
            if (w_cond_taken && !(&r_branch_count)) begin
              w_branch_count_nxt = r_branch_count + CNT_WIDTH'(1);
            end
            if (w_jump && !(&r_jump_count)) begin
              w_jump_count_nxt = r_jump_count + CNT_WIDTH'(1);
            end
          end
        end
      end
      ST_HALT: begin
        // Resume at the instruction following the halt.
        if (in_go) begin
          w_state_nxt = ST_RUN;
          w_pc_nxt    = w_pc_plus4;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      r_state        <= ST_RUN;
      r_pc           <= RESET_PC;
      r_flush        <= 1'b0;
      r_branch_count <= '0;
      r_jump_count   <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_pc           <= w_pc_nxt;
      r_flush        <= w_flush_nxt;
      r_branch_count <= w_branch_count_nxt;
      r_jump_count   <= w_jump_count_nxt;
    end
  end

  assign out_pc           = r_pc;
  assign out_pc_plus4     = w_pc_plus4;
  assign out_taken        = w_taken;
  assign out_flush        = r_flush;
  assign out_halted       = (r_state == ST_HALT);
  assign out_branch_count = r_branch_count;
  assign out_jump_count   = r_jump_count;

endmodule
`default_nettype wire
